// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 ALU function codes, condition selectors and flag layout
// Optional feature macro: Y86_CC_CARRY_EN (adds CF as the low flag bit, CC_W=4).
package y86_pkg;

    localparam logic [1:0] ALUFUN_ADD = 2'd0;
    localparam logic [1:0] ALUFUN_SUB = 2'd1;
    localparam logic [1:0] ALUFUN_AND = 2'd2;
    localparam logic [1:0] ALUFUN_XOR = 2'd3;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;
    localparam logic [3:0] C_B      = 4'd7;

`ifdef Y86_CC_CARRY_EN
    localparam int CC_W   = 4;
    localparam int ZF_BIT = 3;
    localparam int SF_BIT = 2;
    localparam int OF_BIT = 1;
    localparam int CF_BIT = 0;
`else
    localparam int CC_W   = 3;
    localparam int ZF_BIT = 2;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 0;
`endif

endpackage

// File: rtl/y86_cond_eval.sv
// rtl/y86_cond_eval.sv - combinational jXX/cmovXX condition evaluation from committed flags
// Ports: ifun (condition selector), cc (committed flags, layout from y86_pkg), cnd (condition true).
// Optional feature macro: Y86_CC_CARRY_EN (ifun 7 = CF, unsigned-below).
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0]      ifun,
    input  logic [CC_W-1:0] cc,
    output logic            cnd
);

    logic zf;
    logic lt;

    assign zf = cc[ZF_BIT];
    // Signed "less than": the sign is wrong exactly when the operation overflowed.
    assign lt = cc[SF_BIT] ^ cc[OF_BIT];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
`ifdef Y86_CC_CARRY_EN
            C_B:      cnd = cc[CF_BIT];
`endif
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_cc_unit.sv
// rtl/y86_cc_unit.sv - execute-stage condition-code register with flag derivation and branch condition
// Ports: clk, rst_n (async active-low); alu_a/alu_b/alu_y/alufun from the ALU; set_cc, m_stat_bad,
//        w_stat_bad, e_stall pipeline control; e_ifun condition selector; cc_q committed flags,
//        e_cnd condition result, cc_upd one-cycle pulse after each flag write.
// Optional feature macro: Y86_CC_CARRY_EN (cc_q gains CF, one W+1 adder for carry/borrow).
module y86_cc_unit
    import y86_pkg::*;
#(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    alu_a,
    input  logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_y,
    input  logic [1:0]      alufun,
    input  logic            set_cc,
    input  logic            m_stat_bad,
    input  logic            w_stat_bad,
    input  logic            e_stall,
    input  logic [3:0]      e_ifun,
    output logic [CC_W-1:0] cc_q,
    output logic            e_cnd,
    output logic            cc_upd
);

    logic            zf_n;
    logic            sf_n;
    logic            of_n;
    logic [CC_W-1:0] cc_n;
    logic            commit;

    assign zf_n = (alu_y == '0);
    assign sf_n = alu_y[W-1];

    // Overflow from sign bits only; sub computes y = b - a, hence the operand roles swap.
    always_comb begin
        of_n = 1'b0;
        case (alufun)
            ALUFUN_ADD: of_n = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            ALUFUN_SUB: of_n = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_b[W-1]);
            default:    of_n = 1'b0;
        endcase
    end

`ifdef Y86_CC_CARRY_EN
    logic         is_sub;
    logic [W:0]   carry_sum;
    logic         cf_n;

    // b + ~a + 1 sets bit W exactly when b >= a, so borrow is its inverse.
    assign is_sub    = (alufun == ALUFUN_SUB);
    assign carry_sum = {1'b0, alu_b} + {1'b0, (is_sub ? ~alu_a : alu_a)} + {{W{1'b0}}, is_sub};

    always_comb begin
        cf_n = 1'b0;
        case (alufun)
            ALUFUN_ADD: cf_n = carry_sum[W];
            ALUFUN_SUB: cf_n = ~carry_sum[W];
            default:    cf_n = 1'b0;
        endcase
    end

    localparam logic [CC_W-1:0] CC_INIT = {CC_RESET, 1'b0};
    assign cc_n = {zf_n, sf_n, of_n, cf_n};
`else
    localparam logic [CC_W-1:0] CC_INIT = CC_RESET;
    assign cc_n = {zf_n, sf_n, of_n};

    // Only the operand sign bits matter without the carry adder.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{alu_a[W-2:0], alu_b[W-2:0]};
`endif

    // A faulting older instruction in M or W must not let a younger OPq change flags.
    assign commit = set_cc & ~m_stat_bad & ~w_stat_bad & ~e_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q   <= CC_INIT;
            cc_upd <= 1'b0;
        end else begin
            cc_upd <= commit;
            if (commit) begin
                cc_q <= cc_n;
            end
        end
    end

    y86_cond_eval u_cond_eval (
        .ifun (e_ifun),
        .cc   (cc_q),
        .cnd  (e_cnd)
    );

endmodule

// File: tb/tb_y86_cc_unit.sv
// tb/tb_y86_cc_unit.sv - self-checking bench for y86_cc_unit with a behavioural flag/condition model
module tb_y86_cc_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_y;
    logic [1:0]  alufun;
    logic        set_cc;
    logic        m_stat_bad;
    logic        w_stat_bad;
    logic        e_stall;
    logic [3:0]  e_ifun;
    logic [y86_pkg::CC_W-1:0] cc_q;
    logic        e_cnd;
    logic        cc_upd;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2:0] exp_cc;
    logic       exp_lt;
    logic       exp_upd;

    y86_cc_unit #(.W(64), .CC_RESET(3'b100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .alufun     (alufun),
        .set_cc     (set_cc),
        .m_stat_bad (m_stat_bad),
        .w_stat_bad (w_stat_bad),
        .e_stall    (e_stall),
        .e_ifun     (e_ifun),
        .cc_q       (cc_q),
        .e_cnd      (e_cnd),
        .cc_upd     (cc_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags from the mathematical result: overflow means the exact result does not fit in 64 bits;
    // "lt" is whether the exact result is negative.  Returns {zf, sf, of, lt}.
    function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] y, input logic [1:0] fun);
        logic signed [65:0] sa, sb, sy, t;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        sy = {{2{y[63]}}, y};
        case (fun)
            2'd0:    t = sa + sb;
            2'd1:    t = sb - sa;
            default: t = sy;
        endcase
        return {(y == 64'd0), y[63], (t != sy), (t < 0)};
    endfunction

    function automatic logic ref_cond(input logic [3:0] ifun, input logic zf, input logic lt);
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return lt | zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] fun);
        alu_a  = a;
        alu_b  = b;
        alufun = fun;
        case (fun)
            2'd0:    alu_y = a + b;
            2'd1:    alu_y = b - a;
            2'd2:    alu_y = a & b;
            default: alu_y = a ^ b;
        endcase
    endtask

    // Advance one clock and move the model forward using the inputs seen at that edge.
    task automatic cycle();
        logic       commit;
        logic [3:0] f;
        commit = set_cc && !m_stat_bad && !w_stat_bad && !e_stall;
        f = ref_flags(alu_a, alu_b, alu_y, alufun);
        @(posedge clk);
        #1;
        exp_upd = commit;
        if (commit) begin
            exp_cc = f[3:1];
            exp_lt = f[0];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_cc = 1'b0; m_stat_bad = 1'b0; w_stat_bad = 1'b0; e_stall = 1'b0;
        e_ifun = 4'd3;
        set_op(64'd0, 64'd0, 2'd0);
        exp_cc = 3'b100; exp_lt = 1'b0; exp_upd = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL reset_hold cc_q=%b want=100", cc_q); end
        rst_n = 1'b1;
        cycle();
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL reset_cc cc_q=%b want=100", cc_q); end
        n_cmp++;
        if (cc_upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd cc_upd=%b want=0", cc_upd); end
        n_cmp++;
        if (e_cnd !== 1'b1) begin n_fail++; $display("FAIL reset_cnd_e e_cnd=%b want=1", e_cnd); end
    endtask

    task automatic test_add_overflow();
        set_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0);
        set_cc = 1'b1;
        e_ifun = 4'd2;
        cycle();
        set_cc = 1'b0;
        n_cmp++;
        if (alu_y !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL addov_y y=%h", alu_y); end
        n_cmp++;
        if (cc_q !== 3'b011) begin n_fail++; $display("FAIL addov_cc cc_q=%b want=011", cc_q); end
        n_cmp++;
        if (cc_upd !== 1'b1) begin n_fail++; $display("FAIL addov_upd cc_upd=%b want=1", cc_upd); end
        n_cmp++;
        if (e_cnd !== 1'b0) begin n_fail++; $display("FAIL addov_cnd_l e_cnd=%b want=0", e_cnd); end
    endtask

    task automatic test_sub_zero();
        set_op(64'd5, 64'd5, 2'd1);
        set_cc = 1'b1;
        e_ifun = 4'd1;
        cycle();
        set_cc = 1'b0;
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL subz_cc cc_q=%b want=100", cc_q); end
        n_cmp++;
        if (e_cnd !== 1'b1) begin n_fail++; $display("FAIL subz_cnd_le e_cnd=%b want=1", e_cnd); end
        e_ifun = 4'd3; #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin n_fail++; $display("FAIL subz_cnd_e e_cnd=%b want=1", e_cnd); end
        e_ifun = 4'd6; #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin n_fail++; $display("FAIL subz_cnd_g e_cnd=%b want=0", e_cnd); end
    endtask

    task automatic test_exception();
        set_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
        set_cc = 1'b1;
        m_stat_bad = 1'b1;
        cycle();
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL exc_m_cc cc_q=%b want=100", cc_q); end
        n_cmp++;
        if (cc_upd !== 1'b0) begin n_fail++; $display("FAIL exc_m_upd cc_upd=%b want=0", cc_upd); end
        m_stat_bad = 1'b0;
        w_stat_bad = 1'b1;
        cycle();
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL exc_w_cc cc_q=%b want=100", cc_q); end
        w_stat_bad = 1'b0;
        set_cc = 1'b0;
    endtask

    task automatic test_stall();
        int updates;
        updates = 0;
        set_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0);
        set_cc = 1'b1;
        e_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (cc_upd === 1'b1) updates++;
            n_cmp++;
            if (cc_q !== 3'b100) begin n_fail++; $display("FAIL stall_hold%0d cc_q=%b want=100", i, cc_q); end
        end
        e_stall = 1'b0;
        cycle();
        if (cc_upd === 1'b1) updates++;
        set_cc = 1'b0;
        n_cmp++;
        if (cc_q !== 3'b011) begin n_fail++; $display("FAIL stall_release cc_q=%b want=011", cc_q); end
        cycle();
        if (cc_upd === 1'b1) updates++;
        n_cmp++;
        if (updates != 1) begin n_fail++; $display("FAIL stall_updates count=%0d want=1", updates); end
    endtask

    task automatic test_async_reset();
        set_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
        set_cc = 1'b1;
        #4;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL arst_now cc_q=%b want=100", cc_q); end
        @(posedge clk); #1;
        n_cmp++;
        if (cc_q !== 3'b100) begin n_fail++; $display("FAIL arst_edge cc_q=%b want=100", cc_q); end
        n_cmp++;
        if (cc_upd !== 1'b0) begin n_fail++; $display("FAIL arst_upd cc_upd=%b want=0", cc_upd); end
        set_cc = 1'b0;
        rst_n = 1'b1;
        exp_cc = 3'b100; exp_lt = 1'b0; exp_upd = 1'b0;
        cycle();
        n_cmp++;
        if (cc_q !== exp_cc) begin n_fail++; $display("FAIL arst_after cc_q=%b want=%b", cc_q, exp_cc); end
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_op(pick_operand(), pick_operand(), 2'($urandom_range(0, 3)));
            set_cc     = ($urandom_range(0, 9) < 8);
            m_stat_bad = ($urandom_range(0, 9) == 0);
            w_stat_bad = ($urandom_range(0, 9) == 0);
            e_stall    = ($urandom_range(0, 9) < 2);
            e_ifun     = 4'($urandom_range(0, 15));
            cycle();
            n_cmp++;
            if (cc_q !== exp_cc) begin
                n_fail++; $display("FAIL rnd_cc[%0d] cc_q=%b want=%b", i, cc_q, exp_cc);
            end
            n_cmp++;
            if (cc_upd !== exp_upd) begin
                n_fail++; $display("FAIL rnd_upd[%0d] cc_upd=%b want=%b", i, cc_upd, exp_upd);
            end
            n_cmp++;
            if (e_cnd !== ref_cond(e_ifun, exp_cc[2], exp_lt)) begin
                n_fail++;
                $display("FAIL rnd_cnd[%0d] ifun=%0d e_cnd=%b want=%b", i, e_ifun, e_cnd,
                         ref_cond(e_ifun, exp_cc[2], exp_lt));
            end
        end
        set_cc = 1'b0; m_stat_bad = 1'b0; w_stat_bad = 1'b0; e_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_exception();
        test_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
